rsa_const_sequencer: RTL
========================

Name: rsa_const_sequencer

Overview:
- Control block sitting between the RSA decryption top-level and the shared Montgomery-constant engine (R mod M / R^2 mod M divider pair).
- Accepts a modulus over a valid/ready request interface and validates it.
- Formats the engine's wide divisor/accumulator operands, pulses the engine start, and supervises completion with a watchdog.
- Returns both constants (or an error code) over a valid/ready response interface.

Parameters:
- KW, 1024, modulus width in bits; engine r-path is KW+1 bits, t-path is 2*KW bits.
- TIMEOUT_CYC, 16384, max cycles from engine start to engine done before abort.
- CW, 15, watchdog counter width; must satisfy 2^CW > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  modulus request valid
- req_ready  out  1  sequencer can accept a request
- req_mod  in  KW  modulus M
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_r  out  KW  R mod M (engine R_r low KW bits)
- rsp_r2  out  KW  R^2 mod M (engine R_t)
- rsp_err  out  2  0=ok, 1=bad modulus, 2=timeout
- eng_start  out  1  one-cycle engine start pulse
- eng_M_r  out  KW+1  {1'b0, M}
- eng_A_r  out  KW+1  accumulator init, always 0
- eng_M_t  out  2*KW  {KW'b0, M}
- eng_A_t  out  2*KW  accumulator init, always 0
- eng_R_r  in  KW+1  engine remainder, r-path
- eng_R_t  in  KW  engine remainder, t-path
- eng_done  in  1  engine completion, sampled level-high

Behaviour:
- Reset, asynchronous on rst_n low:
  - State goes to IDLE; modulus register, result registers and watchdog clear to 0.
  - req_ready=1, rsp_valid=0, rsp_err=0, eng_start=0.
  - All eng_* operand outputs are 0.
- Reset mid-operation: the engine is abandoned; any in-flight eng_done is ignored after reset.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_mod and go to CHECK.
- CHECK (1 cycle):
  - If M==0, or M[0]==0 (even), or M==1: rsp_err=1, go to RESP without touching the engine.
  - Otherwise go to KICK.
- KICK (1 cycle):
  - eng_start=1; operands are already stable, having been driven from the latched modulus since CHECK.
  - Clear the watchdog, then go to WAIT.
- WAIT:
  - The watchdog increments each cycle.
  - If eng_done=1: capture eng_R_r[KW-1:0] into rsp_r and eng_R_t into rsp_r2, set rsp_err=0, go to RESP. If eng_R_r[KW] is set, treat it as engine error and report rsp_err=2.
  - Else if the watchdog reaches TIMEOUT_CYC-1: rsp_err=2, rsp_r and rsp_r2 forced to 0, go to RESP.
  - eng_done on the same cycle as the timeout is honoured as done, not timeout.
- RESP:
  - rsp_valid=1; rsp_* outputs are held stable until rsp_ready.
  - On rsp_ready, go to IDLE with rsp_valid=0 next cycle.
- req_ready is 0 in every state except IDLE; req_mod is ignored outside IDLE.
- eng_done asserted outside WAIT is ignored.
- Latency, valid modulus: 1 (accept) + 1 (CHECK) + 1 (KICK) + engine cycles + 1, to rsp_valid.
- Latency, bad modulus: rsp_valid 2 cycles after accept.
- Back-to-back: a new request can be accepted the cycle after the rsp handshake.

Optional Feature:
- Macro: RSA_CONST_CACHE_EN.
- Defined:
  - A tag register stores the last modulus that completed with rsp_err=0, plus a tag-valid bit cleared on reset.
  - In CHECK, a valid modulus equal to the tag goes directly to RESP with the stored constants and rsp_err=0.
  - No engine start is issued on a cache hit; hit latency is 2 cycles after accept.
  - A timeout or error invalidates the tag.
- Undefined: no tag logic; every valid modulus runs the engine.

Decomposition:
- Shared package rsa_pkg:
  - state enum (IDLE, CHECK, KICK, WAIT, RESP);
  - rsp_err codes (ERR_OK=0, ERR_MOD=1, ERR_TMO=2);
  - default KW and TIMEOUT_CYC constants.
- One natural sub-module: rsa_watchdog (CW-bit clear/enable counter with terminal-count flag). The FSM and operand formatting stay in the top.

Test Plan:
- M = the 1024-bit odd test modulus used across the design; engine model returns done after 2100 cycles -> exactly one eng_start pulse; eng_M_r={0,M}; eng_M_t={1024'b0,M}; rsp_r/rsp_r2 equal the model values; rsp_err=0.
- M=1024'd6 (even) -> rsp_valid 2 cycles after accept, rsp_err=1, eng_start never asserted.
- Engine model never asserts done, TIMEOUT_CYC=64 -> rsp_valid with rsp_err=2 and rsp_r=rsp_r2=0, 64 cycles after the KICK pulse.
- rsp_ready held low 10 cycles -> rsp_* stable throughout and req_ready=0; second request presented during that time is accepted only after the handshake.
- rst_n pulsed low during WAIT, then eng_done arrives -> all outputs at reset values, no rsp_valid, req_ready=1.
- RSA_CONST_CACHE_EN defined, same valid M requested twice -> second request gets no eng_start, rsp_valid 2 cycles after accept, same constants as the first.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: sequencer states, response error codes and default sizing
// shared by the RSA Montgomery-constant sequencer and its watchdog.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    KICK  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } seq_state_t;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_MOD = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  localparam int DEF_KW          = 1024;
  localparam int DEF_TIMEOUT_CYC = 16384;
  localparam int DEF_CW          = 15;

endpackage

// File: rtl/rsa_watchdog.sv
// rsa_watchdog: clearable, enable-gated cycle counter for engine supervision.
// tc is raised on the enabled cycle whose increment lands on TERMINAL.
module rsa_watchdog #(
  parameter int CW       = 15,
  parameter int TERMINAL = 16383
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CW-1:0] count;

  // Count enabled cycles since the last clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = enable && (count == CW'(TERMINAL - 1));

endmodule

// File: rtl/rsa_const_sequencer.sv
// rsa_const_sequencer: accepts a modulus, rejects unusable ones, drives the
// Montgomery-constant engine and returns R mod M / R^2 mod M or an error.
// Optional macro RSA_CONST_CACHE_EN adds a one-entry cache of the last
// modulus whose constants came back clean, skipping the engine on a repeat.
module rsa_const_sequencer
  import rsa_pkg::*;
#(
  parameter int KW          = DEF_KW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CW          = DEF_CW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [KW-1:0]   req_mod,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [KW-1:0]   rsp_r,
  output logic [KW-1:0]   rsp_r2,
  output logic [1:0]      rsp_err,
  output logic            eng_start,
  output logic [KW:0]     eng_M_r,
  output logic [KW:0]     eng_A_r,
  output logic [2*KW-1:0] eng_M_t,
  output logic [2*KW-1:0] eng_A_t,
  input  logic [KW:0]     eng_R_r,
  input  logic [KW-1:0]   eng_R_t,
  input  logic            eng_done
);

  seq_state_t state, next_state;

  logic [KW-1:0] mod_q;
  logic [KW-1:0] rsp_r_q;
  logic [KW-1:0] rsp_r2_q;
  logic [1:0]    rsp_err_q;
  logic          mod_bad;
  logic          cache_hit;
  logic          wd_clear;
  logic          wd_en;
  logic          wd_tc;

  // Montgomery needs an odd modulus above one; zero is caught by the odd test too.
  assign mod_bad = (mod_q == '0) || !mod_q[0] || (mod_q == KW'(1));

`ifdef RSA_CONST_CACHE_EN
  logic [KW-1:0] tag_q;
  logic          tag_valid_q;

  // Track the last cleanly computed modulus; any error result drops the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else if (state == CHECK && mod_bad) begin
      tag_valid_q <= 1'b0;
    end else if (state == WAIT) begin
      if (eng_done) begin
        if (eng_R_r[KW]) begin
          tag_valid_q <= 1'b0;
        end else begin
          tag_q       <= mod_q;
          tag_valid_q <= 1'b1;
        end
      end else if (wd_tc) begin
        tag_valid_q <= 1'b0;
      end
    end
  end

  assign cache_hit = tag_valid_q && (tag_q == mod_q);
`else
  assign cache_hit = 1'b0;
`endif

  // State register; reset abandons any engine run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake/engine control decoded from the current state.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    eng_start  = 1'b0;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = CHECK;
      end
      CHECK: begin
        if (mod_bad || cache_hit) next_state = RESP;
        else                      next_state = KICK;
      end
      KICK: begin
        eng_start  = 1'b1;
        wd_clear   = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        if (eng_done || wd_tc) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the modulus on acceptance and settle the response fields as each decision is made.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_q     <= '0;
      rsp_r_q   <= '0;
      rsp_r2_q  <= '0;
      rsp_err_q <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) mod_q <= req_mod;
        end
        CHECK: begin
          if (mod_bad) begin
            rsp_err_q <= ERR_MOD;
            rsp_r_q   <= '0;
            rsp_r2_q  <= '0;
          end else if (cache_hit) begin
            rsp_err_q <= ERR_OK;
          end
        end
        WAIT: begin
          if (eng_done) begin
            if (eng_R_r[KW]) begin
              rsp_err_q <= ERR_TMO;
              rsp_r_q   <= '0;
              rsp_r2_q  <= '0;
            end else begin
              rsp_err_q <= ERR_OK;
              rsp_r_q   <= eng_R_r[KW-1:0];
              rsp_r2_q  <= eng_R_t;
            end
          end else if (wd_tc) begin
            rsp_err_q <= ERR_TMO;
            rsp_r_q   <= '0;
            rsp_r2_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  rsa_watchdog #(
    .CW       (CW),
    .TERMINAL (TIMEOUT_CYC - 1)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .tc     (wd_tc)
  );

  assign rsp_r   = rsp_r_q;
  assign rsp_r2  = rsp_r2_q;
  assign rsp_err = rsp_err_q;
  assign eng_M_r = {1'b0, mod_q};
  assign eng_A_r = '0;
  assign eng_M_t = {{KW{1'b0}}, mod_q};
  assign eng_A_t = '0;

endmodule
